// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly behind the program counter.
// Issues one instruction-memory read per PC value, buffers returned words
// (tagged with their PC) in a small FIFO and hands them to the decoder over a
// valid/ready handshake. pc_advance tells the PC to step only when a fetch is
// accepted by memory. flush discards everything fetched or still in flight.
//
// Optional feature: define FETCH_PERF_CNT_EN to add saturating 16-bit
// fetch/stall performance counters (perf_fetch_cnt, perf_stall_cnt).
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   pc_in          current PC value
//   pc_advance     one-cycle pulse enabling the PC to step
//   flush          branch/jump taken; drop all fetched and in-flight words
//   imem_req       read request valid
//   imem_addr      read address (registered, stable until accepted)
//   imem_ready     memory accepts the request this cycle
//   imem_rvalid    read data valid
//   imem_rdata     read data
//   dec_valid      instruction available to the decoder
//   dec_instr      instruction word at FIFO head
//   dec_pc         address of dec_instr
//   dec_ready      decoder accepts the instruction
//   perf_fetch_cnt FIFO pops (FETCH_PERF_CNT_EN only)
//   perf_stall_cnt cycles the decoder waited on an empty fetch stage
//                  (FETCH_PERF_CNT_EN only)
//
// State table:
//   state  | meaning
//   IDLE   | no request outstanding
//   REQ    | imem_req high, waiting for imem_ready
//   WAIT   | request accepted, awaiting imem_rvalid

module fetch_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   pc_advance,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   dec_valid,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  input  logic                   dec_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            perf_fetch_cnt,
  output logic [15:0]            perf_stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  pending_pc_q, pending_pc_d;
  logic                   discard_q, discard_d;

  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_buf_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_buf_q    [BUF_DEPTH];

  logic push;
  logic pop;
  logic space_after_push;

  // A flush cycle hides the head so any handshake in that cycle is void.
  assign dec_valid = (count_q != '0) && !flush;
  assign dec_instr = instr_buf_q[rd_ptr_q];
  assign dec_pc    = pc_buf_q[rd_ptr_q];
  assign imem_addr = addr_q;

  assign pop  = dec_valid && dec_ready;
  assign push = (state_q == S_WAIT) && imem_rvalid && !discard_q && !flush;

  // Room for another request once this response lands, crediting a pop in
  // the same cycle so streaming keeps going with a full-rate decoder.
  assign space_after_push =
    (count_q + CNT_W'(1) - CNT_W'(pop)) < DEPTH_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      pending_pc_q <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pending_pc_q <= pending_pc_d;
      discard_q    <= discard_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pending_pc_d = pending_pc_q;
    discard_d    = discard_q;
    imem_req     = 1'b0;
    pc_advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < DEPTH_C)) begin
          state_d = S_REQ;
          addr_d  = pc_in;
        end
      end

      S_REQ: begin
        // Request is withdrawn in the flush cycle so memory cannot accept it.
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            pc_advance   = 1'b1;
            pending_pc_d = addr_q;
            state_d      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          // Response arriving with the flush is simply dropped; otherwise
          // remember to drop the one still in flight.
          if (imem_rvalid) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          discard_d = 1'b0;
          if (!discard_q && space_after_push) begin
            state_d = S_REQ;
            addr_d  = pc_in;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_buf_q[i] <= '0;
        pc_buf_q[i]    <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        instr_buf_q[wr_ptr_q] <= imem_rdata;
        pc_buf_q[wr_ptr_q]    <= pending_pc_q;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && (perf_fetch_cnt != 16'hFFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (dec_ready && !dec_valid && !flush && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        dec_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // PC model: steps on pc_advance, loads a branch target on request.
  logic [7:0] pc_rst_val;
  logic       pc_load_en;
  logic [7:0] pc_load_val;
  always @(posedge clk or posedge reset) begin
    if (reset)            pc <= pc_rst_val;
    else if (pc_load_en)  pc <= pc_load_val;
    else if (pc_advance)  pc <= pc + 8'd1;
  end

  // Memory model: word at address a is {~a, a}; latency mem_lat cycles.
  int          mem_lat;
  int          mem_cnt;
  logic [7:0]  mem_paddr;
  logic        mem_rvalid_q;
  logic [15:0] mem_rdata_q;
  logic        inj_rvalid;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cnt      <= 0;
      mem_paddr    <= 8'h00;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= 16'h0000;
    end else begin
      mem_rvalid_q <= 1'b0;
      if (mem_cnt == 1) begin
        mem_rvalid_q <= 1'b1;
        mem_rdata_q  <= {~mem_paddr, mem_paddr};
        mem_cnt      <= 0;
      end else if (mem_cnt > 1) begin
        mem_cnt <= mem_cnt - 1;
      end
      if (imem_req && imem_ready) begin
        if (mem_lat == 1) begin
          mem_rvalid_q <= 1'b1;
          mem_rdata_q  <= {~imem_addr, imem_addr};
        end else begin
          mem_cnt   <= mem_lat - 1;
          mem_paddr <= imem_addr;
        end
      end
    end
  end
  assign imem_rvalid = mem_rvalid_q | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? 16'hDEAD : mem_rdata_q;

  // Observers of pops and pc_advance pulses.
  int         adv_cnt = 0;
  logic [7:0]  pop_pc_q [$];
  logic [15:0] pop_instr_q [$];
  always @(posedge clk) begin
    if (!reset && pc_advance) adv_cnt <= adv_cnt + 1;
    if (!reset && dec_valid && dec_ready) begin
      pop_pc_q.push_back(dec_pc);
      pop_instr_q.push_back(dec_instr);
    end
  end

  int pop_base;
  int adv_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  // Hold reset for two cycles, then release just after a falling edge.
  task automatic start(input logic [7:0] v);
    @(negedge clk);
    #1;
    reset      = 1'b1;
    pc_rst_val = v;
    flush      = 1'b0;
    inj_rvalid = 1'b0;
    pc_load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    pop_base = pop_pc_q.size();
    adv_base = adv_cnt;
    reset    = 1'b0;
  endtask

  task automatic wait_dec(input string tag, input int budget);
    int n = 0;
    while (dec_valid !== 1'b1 && n < budget) begin
      nx();
      #1;
      n++;
    end
    chk(tag, 32'(dec_valid), 32'(1));
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    dec_ready   = 1'b1;
    imem_ready  = 1'b1;
    pc_rst_val  = 8'h00;
    pc_load_en  = 1'b0;
    pc_load_val = 8'h00;
    mem_lat     = 1;
    inj_rvalid  = 1'b0;
    pop_base    = 0;
    adv_base    = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req",   32'(imem_req),   32'(0));
    chk("rst_adv",   32'(pc_advance), 32'(0));
    chk("rst_valid", 32'(dec_valid),  32'(0));
    chk("rst_addr",  32'(imem_addr),  32'(0));
    chk("rst_instr", 32'(dec_instr),  32'(0));
    chk("rst_pc",    32'(dec_pc),     32'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", 32'(perf_fetch_cnt), 32'(0));
    chk("rst_perf_stall", 32'(perf_stall_cnt), 32'(0));
`endif

    // Streaming from PC 0 with a ready decoder and 1-cycle memory
    dec_ready = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    start(8'h00);
    nx(); #1;
    chk("t1_req",    32'(imem_req),   32'(1));
    chk("t1_addr",   32'(imem_addr),  32'(8'h00));
    chk("t1_adv",    32'(pc_advance), 32'(1));
    chk("t1_valid0", 32'(dec_valid),  32'(0));
    nx(); #1;
    chk("t1_valid1", 32'(dec_valid),  32'(0));
    nx(); #1;
    chk("t1_valid2", 32'(dec_valid),  32'(1));
    chk("t1_pc0",    32'(dec_pc),     32'(8'h00));
    chk("t1_instr0", 32'(dec_instr),  32'(16'hFF00));
`ifdef FETCH_PERF_CNT_EN
    chk("t1_perf_stall", 32'(perf_stall_cnt), 32'(3));
    chk("t1_perf_fetch", 32'(perf_fetch_cnt), 32'(0));
`endif
    repeat (6) nx();
    #1;
    chk("t1_npops", 32'(pop_pc_q.size() - pop_base), 32'(3));
    chk("t1_pop0",  32'(pop_pc_q[pop_base]),     32'(8'h00));
    chk("t1_pop1",  32'(pop_pc_q[pop_base + 1]), 32'(8'h01));
    chk("t1_pop2",  32'(pop_pc_q[pop_base + 2]), 32'(8'h02));
    chk("t1_ins2",  32'(pop_instr_q[pop_base + 2]), 32'(16'hFD02));

    // Decoder stalled: FIFO fills with 0x00,0x01 and fetching stops
    dec_ready = 1'b0;
    start(8'h00);
    repeat (5) nx();
    for (int i = 0; i < 4; i++) begin
      nx(); #1;
      chk("t2_req",   32'(imem_req),   32'(0));
      chk("t2_adv",   32'(pc_advance), 32'(0));
      chk("t2_valid", 32'(dec_valid),  32'(1));
      chk("t2_pc",    32'(dec_pc),     32'(8'h00));
      chk("t2_instr", 32'(dec_instr),  32'(16'hFF00));
    end
    chk("t2_pcstall", 32'(pc), 32'(8'h02));
    nx();
    dec_ready = 1'b1;
    nx(); #1;
    chk("t2_head1",  32'(dec_pc),    32'(8'h01));
    chk("t2_valid1", 32'(dec_valid), 32'(1));
    nx(); #1;
    chk("t2_resume_req",  32'(imem_req),  32'(1));
    chk("t2_resume_addr", 32'(imem_addr), 32'(8'h02));
    chk("t2_empty",       32'(dec_valid), 32'(0));
    repeat (4) nx();
    #1;
    chk("t2_npops", 32'(pop_pc_q.size() - pop_base), 32'(3));
    chk("t2_pop0",  32'(pop_pc_q[pop_base]),     32'(8'h00));
    chk("t2_pop1",  32'(pop_pc_q[pop_base + 1]), 32'(8'h01));
    chk("t2_pop2",  32'(pop_pc_q[pop_base + 2]), 32'(8'h02));

    // Memory not ready: request for 0x05 held stable, one pc_advance
    dec_ready = 1'b1; imem_ready = 1'b0; mem_lat = 1;
    start(8'h05);
    for (int i = 0; i < 4; i++) begin
      nx(); #1;
      chk("t3_req",  32'(imem_req),   32'(1));
      chk("t3_addr", 32'(imem_addr),  32'(8'h05));
      chk("t3_adv",  32'(pc_advance), 32'(0));
    end
    imem_ready = 1'b1;
    #1;
    chk("t3_adv_accept", 32'(pc_advance), 32'(1));
    nx(); #1;
    chk("t3_adv_count", 32'(adv_cnt - adv_base), 32'(1));
    chk("t3_req_drop",  32'(imem_req), 32'(0));
    chk("t3_pc",        32'(pc), 32'(8'h06));
    nx(); #1;
    chk("t3_valid", 32'(dec_valid), 32'(1));
    chk("t3_dpc",   32'(dec_pc),    32'(8'h05));
    chk("t3_instr", 32'(dec_instr), 32'(16'hFA05));

    // Flush while waiting on 0x07 with 0x06 buffered
    dec_ready = 1'b0; imem_ready = 1'b1; mem_lat = 1;
    start(8'h06);
    nx();
    nx();
    mem_lat = 3;
    nx();
    nx(); #1;
    chk("t4_buf_valid", 32'(dec_valid), 32'(1));
    chk("t4_buf_pc",    32'(dec_pc),    32'(8'h06));
    flush = 1'b1; pc_load_en = 1'b1; pc_load_val = 8'h40;
    #1;
    chk("t4_fl_valid", 32'(dec_valid),  32'(0));
    chk("t4_fl_adv",   32'(pc_advance), 32'(0));
    chk("t4_fl_req",   32'(imem_req),   32'(0));
    nx();
    flush = 1'b0; pc_load_en = 1'b0; dec_ready = 1'b1;
    #1;
    chk("t4_emptied", 32'(dec_valid), 32'(0));
    chk("t4_req5",    32'(imem_req),  32'(0));
    nx(); #1;
    chk("t4_req6",    32'(imem_req),  32'(0));
    nx(); #1;
    chk("t4_req7",    32'(imem_req),  32'(0));
    chk("t4_drop",    32'(dec_valid), 32'(0));
    nx(); #1;
    chk("t4_new_req",  32'(imem_req),  32'(1));
    chk("t4_new_addr", 32'(imem_addr), 32'(8'h40));
    wait_dec("t4_wait_valid", 12);
    chk("t4_dpc",   32'(dec_pc),    32'(8'h40));
    chk("t4_instr", 32'(dec_instr), 32'(16'hBF40));
    chk("t4_nopop", 32'(pop_pc_q.size() - pop_base), 32'(0));

    // Flush with imem_rvalid, then flush with a decoder handshake
    dec_ready = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    start(8'h10);
    nx();
    nx();
    flush = 1'b1; pc_load_en = 1'b1; pc_load_val = 8'h20;
    #1;
    chk("t5_rv_valid", 32'(dec_valid),  32'(0));
    chk("t5_rv_adv",   32'(pc_advance), 32'(0));
    nx();
    flush = 1'b0; pc_load_en = 1'b0;
    #1;
    chk("t5_rv_empty", 32'(dec_valid), 32'(0));
    chk("t5_rv_idle",  32'(imem_req),  32'(0));
    nx(); #1;
    chk("t5_req20",  32'(imem_req),  32'(1));
    chk("t5_addr20", 32'(imem_addr), 32'(8'h20));
    nx();
    nx(); #1;
    chk("t5_valid20", 32'(dec_valid), 32'(1));
    chk("t5_dpc20",   32'(dec_pc),    32'(8'h20));
    chk("t5_ins20",   32'(dec_instr), 32'(16'hDF20));
    flush = 1'b1; pc_load_en = 1'b1; pc_load_val = 8'h30;
    #1;
    chk("t5_hs_valid", 32'(dec_valid),  32'(0));
    chk("t5_hs_req",   32'(imem_req),   32'(0));
    chk("t5_hs_adv",   32'(pc_advance), 32'(0));
    nx();
    flush = 1'b0; pc_load_en = 1'b0;
    #1;
    chk("t5_hs_empty", 32'(dec_valid), 32'(0));
    chk("t5_npops",    32'(pop_pc_q.size() - pop_base), 32'(0));
    nx(); #1;
    chk("t5_req30",  32'(imem_req),  32'(1));
    chk("t5_addr30", 32'(imem_addr), 32'(8'h30));
    wait_dec("t5_wait_valid", 8);
    chk("t5_dpc30", 32'(dec_pc),    32'(8'h30));
    chk("t5_ins30", 32'(dec_instr), 32'(16'hCF30));

    // Reset while waiting, one word buffered
    dec_ready = 1'b0; imem_ready = 1'b1; mem_lat = 1;
    start(8'h50);
    nx();
    nx();
    mem_lat = 3;
    nx();
    nx(); #1;
    chk("t6_valid", 32'(dec_valid), 32'(1));
    chk("t6_dpc",   32'(dec_pc),    32'(8'h50));
    chk("t6_ins",   32'(dec_instr), 32'(16'hAF50));
    reset = 1'b1;
    #1;
    chk("t6_rst_req",   32'(imem_req),   32'(0));
    chk("t6_rst_adv",   32'(pc_advance), 32'(0));
    chk("t6_rst_valid", 32'(dec_valid),  32'(0));
    chk("t6_rst_addr",  32'(imem_addr),  32'(0));
    chk("t6_rst_instr", 32'(dec_instr),  32'(0));
    chk("t6_rst_pc",    32'(dec_pc),     32'(0));
`ifdef FETCH_PERF_CNT_EN
    chk("t6_rst_perf_fetch", 32'(perf_fetch_cnt), 32'(0));
    chk("t6_rst_perf_stall", 32'(perf_stall_cnt), 32'(0));
`endif
    nx();
    reset = 1'b0; inj_rvalid = 1'b1;
    nx();
    inj_rvalid = 1'b0;
    #1;
    chk("t6_ignored", 32'(dec_valid), 32'(0));
    chk("t6_restart_req",  32'(imem_req),  32'(1));
    chk("t6_restart_addr", 32'(imem_addr), 32'(8'h50));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
